// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
// Defining UART_TX_PARITY_EN adds the even-parity state.
package uart_tx_fifo_pkg;

    localparam logic        UART_IDLE_LEVEL = 1'b1;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TX_PARITY_EN
        StParity,
`endif
        StStop
    } tx_state_e;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with fall-through read data; pointers wrap modulo DEPTH (power of two).
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full     = (r_count == FULL_COUNT);
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_wr_en    = i_push & ~o_full;
    assign w_rd_en    = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1) fed by a byte FIFO; queued bytes go out back-to-back.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop (8E1).
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int unsigned DELAY_FRAMES = 234,
    parameter int unsigned DEPTH        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   uart_tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int unsigned CNT_W = $clog2(DELAY_FRAMES + 1);
    localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    tx_state_e                 r_state;
    tx_state_e                 w_state_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_bit_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [UART_DATA_BITS-1:0] w_fifo_data;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_full;
    logic                      w_empty;
    logic                      w_bit_done;

    assign in_ready   = ~w_full;
    assign w_push     = in_valid & ~w_full;
    assign w_bit_done = (r_cnt == CNT_LAST);

    uart_byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (in_data),
        .i_pop       (w_pop),
        .o_pop_data  (w_fifo_data),
        .o_count     (fifo_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StStart;
                end
            end
            StStart: begin
                if (w_bit_done) w_state_next = StData;
            end
`ifdef UART_TX_PARITY_EN
            StData: begin
                if (w_bit_done && r_bit_idx == IDX_LAST) w_state_next = StParity;
            end
            StParity: begin
                if (w_bit_done) w_state_next = StStop;
            end
`else
            StData: begin
                if (w_bit_done && r_bit_idx == IDX_LAST) w_state_next = StStop;
            end
`endif
            StStop: begin
                // Chain straight into the next start bit when more data is queued.
                if (w_bit_done) begin
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = StStart;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        uart_tx = UART_IDLE_LEVEL;
        busy    = (r_state != StIdle);
        unique case (r_state)
            StStart:  uart_tx = ~UART_IDLE_LEVEL;
            StData:   uart_tx = r_shift[r_bit_idx];
`ifdef UART_TX_PARITY_EN
            StParity: uart_tx = even_parity(r_shift);
`endif
            default:  uart_tx = UART_IDLE_LEVEL;
        endcase
    end

    // Bit timer restarts at every bit boundary and is held cleared while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (w_pop) begin
                r_shift   <= w_fifo_data;
                r_bit_idx <= '0;
            end else if (r_state == StData && w_bit_done) begin
                r_bit_idx <= r_bit_idx + 1'b1;
            end
            if (r_state == StIdle || w_bit_done) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed frame table, corner sequences and
// randomized traffic against a frame-schedule reference model.
module tb_uart_tx_fifo;
    localparam int unsigned DELAY = 8;
    localparam int unsigned DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS  = 11;
    localparam bit          PAR_EN = 1'b1;
`else
    localparam int unsigned NBITS  = 10;
    localparam bit          PAR_EN = 1'b0;
`endif
    localparam int unsigned FRAME = NBITS * DELAY;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_fifo #(
        .DELAY_FRAMES (DELAY),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int unsigned edge_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edge_n, act, exp);
        end
    endtask

    // Reference model: each accepted byte is scheduled to start at
    // max(accept_edge + 1, end of the previous frame) and occupies FRAME cycles.
    typedef struct {
        logic [7:0]  d;
        int unsigned st;
    } frm_t;

    frm_t        mq[$];
    int unsigned m_line_free = 0;
    bit          m_acc = 1'b0;
    int unsigned m_acc_edge = 0;
    bit          chk_en = 1'b0;

    function automatic int m_count(input int unsigned t);
        int n = 0;
        foreach (mq[i]) if (mq[i].st > t) n++;
        return n;
    endfunction

    function automatic logic frame_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PAR_EN && b == 9) return ^d;
        return 1'b1;
    endfunction

    function automatic logic m_tx(input int unsigned t);
        foreach (mq[i]) begin
            if (mq[i].st <= t && t < mq[i].st + FRAME) return frame_bit(mq[i].d, int'((t - mq[i].st) / DELAY));
        end
        return 1'b1;
    endfunction

    function automatic logic m_busy(input int unsigned t);
        foreach (mq[i]) if (mq[i].st <= t && t < mq[i].st + FRAME) return 1'b1;
        return 1'b0;
    endfunction

    always @(negedge rst_n) begin
        mq.delete();
        m_line_free = 0;
    end

    initial begin
        frm_t f;
        forever begin
            @(posedge clk);
            edge_n++;
            m_acc = 1'b0;
            if (rst_n === 1'b1 && in_valid === 1'b1 && m_count(edge_n - 1) < DEPTH) begin
                f.d  = in_data;
                f.st = (m_line_free > edge_n + 1) ? m_line_free : edge_n + 1;
                mq.push_back(f);
                m_line_free = f.st + FRAME;
                m_acc       = 1'b1;
                m_acc_edge  = edge_n;
            end
            #1;
            while (mq.size() > 0 && mq[0].st + FRAME <= edge_n) void'(mq.pop_front());
            if (chk_en) begin
                check("model_tx", uart_tx, m_tx(edge_n));
                check("model_busy", busy, m_busy(edge_n));
                check("model_count", fifo_count, m_count(edge_n));
                check("model_ready", in_ready, m_count(edge_n) < DEPTH);
            end
        end
    end

    // Line receiver: samples mid-bit, collects data bytes in arrival order.
    logic [7:0] rx_q[$];
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge uart_tx);
            repeat (DELAY / 2) @(posedge clk);
            #1;
            for (int i = 0; i < 8; i++) begin
                repeat (DELAY) @(posedge clk);
                #1;
                b[i] = uart_tx;
            end
            rx_q.push_back(b);
            repeat ((NBITS - 9) * DELAY) @(posedge clk);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog at edge %0d: got timeout expected completion", edge_n);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_idle();
        int g = 0;
        while (m_line_free > edge_n && g < 3000) begin
            tick();
            g++;
        end
        check("drain_bound", g < 3000, 1);
        tick();
        tick();
    endtask

    typedef struct {
        logic [7:0] data;
        logic [9:0] line;  // start at bit 0, stop at bit 9, data LSB-first between
        logic       par;
    } vec_t;

    function automatic logic row_bit(input vec_t v, input int idx);
        if (PAR_EN && idx == 9) return v.par;
        if (PAR_EN && idx == 10) return v.line[9];
        return v.line[idx];
    endfunction

    initial begin
        vec_t vt[8];
        int   nb;
        int   k;
        int   g;
        int   lows;
        int   pct;
        int unsigned base;
        int   acc_rel[6];

        vt[0] = '{8'h41, 10'b1010000010, 1'b0};
        vt[1] = '{8'h55, 10'b1010101010, 1'b0};
        vt[2] = '{8'hAA, 10'b1101010100, 1'b0};
        vt[3] = '{8'h07, 10'b1000001110, 1'b1};
        vt[4] = '{8'h03, 10'b1000000110, 1'b0};
        vt[5] = '{8'h00, 10'b1000000000, 1'b0};
        vt[6] = '{8'hFF, 10'b1111111110, 1'b0};
        vt[7] = '{8'h80, 10'b1100000000, 1'b1};
        foreach (acc_rel[i]) acc_rel[i] = -1;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) tick();
        check("reset_tx", uart_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_count", fifo_count, 0);
        check("reset_ready", in_ready, 1);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        tick();
        check("post_release_tx", uart_tx, 1);

        // Single frames from an idle line
        foreach (vt[r]) begin
            in_valid = 1'b1;
            in_data  = vt[r].data;
            tick();
            in_valid = 1'b0;
            check("tbl_count_after_push", fifo_count, 1);
            check("tbl_line_before_start", uart_tx, 1);
            nb = 0;
            for (int c = 0; c < int'(FRAME); c++) begin
                tick();
                check("tbl_line", uart_tx, row_bit(vt[r], c / int'(DELAY)));
                if (busy === 1'b1) nb++;
            end
            check("tbl_busy_cycles", nb, FRAME);
            tick();
            check("tbl_end_busy", busy, 0);
            check("tbl_end_line", uart_tx, 1);
            check("tbl_end_count", fifo_count, 0);
        end

        // Two bytes in consecutive cycles leave no gap between frames
        wait_idle();
        in_valid = 1'b1;
        in_data  = 8'h55;
        tick();
        in_data  = 8'hAA;
        tick();
        in_valid = 1'b0;
        nb = 0;
        for (int c = 0; c < int'(2 * FRAME + 4); c++) begin
            if (c > 0) tick();
            if (busy === 1'b1) nb++;
            if (c == int'(FRAME) - 1) check("b2b_first_stop", uart_tx, 1);
            if (c == int'(FRAME)) check("b2b_second_start", uart_tx, 0);
        end
        check("b2b_busy_cycles", nb, 2 * FRAME);

        // Hold in_valid for six bytes while the first is on the line
        wait_idle();
        rx_q.delete();
        base     = edge_n;
        in_valid = 1'b1;
        in_data  = 8'd1;
        k = 0;
        g = 0;
        while (k < 6 && g < 500) begin
            tick();
            g++;
            if (m_acc) begin
                acc_rel[k] = int'(m_acc_edge - base - 1);
                k++;
                in_data = 8'(k + 1);
                if (k == 5) begin
                    check("fill_count_full", fifo_count, 4);
                    check("fill_ready_low", in_ready, 0);
                end
            end
        end
        in_valid = 1'b0;
        check("fill_accept_bound", k, 6);
        check("fill_fifth_rel", acc_rel[4], 4);
        check("fill_sixth_rel", acc_rel[5], FRAME + 2);
        wait_idle();
        check("fill_rx_count", rx_q.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) check("fill_rx_order", rx_q[i], i + 1);
        end

        // Randomized traffic at several offered loads
        for (int ph = 0; ph < 3; ph++) begin
            pct = (ph == 0) ? 20 : (ph == 1) ? 60 : 95;
            for (int n = 0; n < 1200; n++) begin
                in_valid = ($urandom_range(0, 99) < pct);
                in_data  = 8'($urandom);
                tick();
            end
            in_valid = 1'b0;
            wait_idle();
        end

        // Reset 30 cycles into a frame with bytes still queued
        in_valid = 1'b1;
        in_data  = 8'h5A;
        tick();
        in_data  = 8'h3C;
        tick();
        in_data  = 8'h99;
        tick();
        in_valid = 1'b0;
        repeat (29) tick();
        check("rst_pre_busy", busy, 1);
        check("rst_pre_count", fifo_count, 2);
        #1 rst_n = 1'b0;
        #1;
        check("rst_abort_tx", uart_tx, 1);
        check("rst_abort_count", fifo_count, 0);
        check("rst_abort_busy", busy, 0);
        check("rst_abort_ready", in_ready, 1);
        repeat (3) tick();
        rst_n = 1'b1;
        lows = 0;
        repeat (100) begin
            tick();
            if (uart_tx !== 1'b1) lows++;
        end
        check("rst_line_stays_high", lows, 0);
        check("rst_stays_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter DELAY_FRAMES, default 234, meaning clocks per UART bit (27 MHz / 115200).
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  system clock; the only clock.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_data  input  8  byte to transmit.
REQ-006 SHALL have port in_valid  input  1  in_data is valid.
REQ-007 SHALL have port in_ready  output  1  FIFO can accept a byte; high when FIFO not full.
REQ-008 SHALL have port uart_tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high when the serializer is in any state other than IDLE.
REQ-010 SHALL have port fifo_count  output  $clog2(DEPTH)+1  bytes held in the FIFO, excluding the byte in the serializer.

Function
REQ-011 SHALL accept a byte on every rising clk edge where in_valid && in_ready; the transfer SHALL be visible in fifo_count after that edge.
REQ-012 SHALL hold in_ready low while fifo_count == DEPTH; in_valid while full is ignored and causes no data loss or corruption.
REQ-013 SHALL leave fifo_count unchanged on a simultaneous push and pop; read/write pointers wrap modulo DEPTH.
REQ-014 Serializer FSM states SHALL be IDLE, START, DATA, PARITY (macro only), STOP.
REQ-015 In IDLE with fifo_count > 0, SHALL pop one byte on the next edge and enter START; uart_tx goes low after that edge.
REQ-016 A byte pushed into an empty FIFO at edge N SHALL drive the start bit from edge N+1.
REQ-017 Each bit (start, 8 data LSB-first, parity, stop) SHALL last exactly DELAY_FRAMES clocks, timed by a bit counter reloaded at each bit boundary.
REQ-018 At the end of STOP with fifo_count > 0, SHALL pop and enter START directly, so frames are back-to-back with no idle gap; otherwise SHALL return to IDLE.
REQ-019 Frame length SHALL be 10*DELAY_FRAMES clocks without the macro and 11*DELAY_FRAMES clocks with it.
REQ-020 SHALL hold uart_tx high in IDLE and STOP.

Reset
REQ-021 On rst_n low, SHALL asynchronously clear pointers, fifo_count=0, state=IDLE, uart_tx=1, busy=0, in_ready=1, and bit and cycle counters.
REQ-022 Reset during a frame SHALL abort the frame immediately, with uart_tx high and FIFO contents discarded.
REQ-023 First activity after reset release SHALL occur no earlier than the first edge with rst_n high.

Configuration
REQ-024 Macro UART_TX_PARITY_EN, if defined, SHALL insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP.
REQ-025 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent and the frame SHALL be 8N1.

Structure
REQ-026 A shared package SHALL hold the FSM state enum and constants UART_IDLE_LEVEL=1 and UART_DATA_BITS=8.
REQ-027 FIFO storage and pointers SHALL be a sub-module named uart_byte_fifo; the serializer FSM SHALL live in uart_tx_fifo.

Verification (DELAY_FRAMES=8, DEPTH=4)
REQ-028 Push 0x41 to an idle block: uart_tx low from the next edge, then 8 cycles each of 1,0,0,0,0,0,1,0, then high 8 cycles; busy high for 80 cycles.
REQ-029 Push 0x55 and 0xAA in consecutive cycles: two frames back-to-back, stop bit of the first immediately followed by the start bit of the second; total 160 cycles busy.
REQ-030 Hold in_valid for 6 bytes 0x01..0x06 while the first is transmitting: in_ready drops when fifo_count=4, the 6th byte is accepted only after a pop, and all 6 bytes are emitted in order.
REQ-031 Assert rst_n low at cycle 30 of a frame: uart_tx=1, fifo_count=0, busy=0 immediately; with no new push, the line stays high.
REQ-032 With UART_TX_PARITY_EN, push 0x07: parity bit=1, frame 88 cycles; push 0x03: parity bit=0.
